// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for data hazards, taken branches and multi-cycle multiplies.
// Define PIPE_FWD_EN when a forwarding unit is present, which limits data stalls to load-use hazards.
module pipeline_hazard_ctrl #(
  parameter int REG_W       = 5,
  parameter int ZERO_REG    = 31,
  parameter int MUL_MAX_CYC = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_regwrite,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_regwrite,
  input  logic             br_taken,
  input  logic             mul_start,
  input  logic             mul_done,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic [CNT_W-1:0] stall_count,
  output logic             mul_timeout
);
  localparam logic RUN      = 1'b0;
  localparam logic MUL_WAIT = 1'b1;
  localparam int   MC_W     = $clog2(MUL_MAX_CYC + 1);
  localparam logic [REG_W-1:0] ZR = REG_W'(ZERO_REG);
  localparam logic [MC_W-1:0]  MC_LAST = MC_W'(MUL_MAX_CYC - 1);

  logic             state_q, state_d;
  logic [MC_W-1:0]  mul_cnt_q, mul_cnt_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic             mul_timeout_q, mul_timeout_d;

  logic dep_ex1, dep_ex2, dep_mem1, dep_mem2, load_use, data_stall;
  logic in_wait, run_plain, run_br, run_stall, mul_last, mul_end;

  assign dep_ex1  = id_valid & id_use_rs1 & ex_regwrite & (ex_rd == id_rs1) & (id_rs1 != ZR);
  assign dep_ex2  = id_valid & id_use_rs2 & ex_regwrite & (ex_rd == id_rs2) & (id_rs2 != ZR);
  assign dep_mem1 = id_valid & id_use_rs1 & mem_regwrite & (mem_rd == id_rs1) & (id_rs1 != ZR);
  assign dep_mem2 = id_valid & id_use_rs2 & mem_regwrite & (mem_rd == id_rs2) & (id_rs2 != ZR);
  assign load_use = ex_memread & (dep_ex1 | dep_ex2);
`ifdef PIPE_FWD_EN
  assign data_stall = load_use;
`else
  assign data_stall = load_use | dep_ex1 | dep_ex2 | dep_mem1 | dep_mem2;
`endif

  // mul_start outranks branch and data terms; that cycle itself runs unstalled
  assign in_wait   = state_q == MUL_WAIT;
  assign run_plain = !in_wait & !mul_start;
  assign run_br    = run_plain & br_taken;
  assign run_stall = run_plain & !br_taken & data_stall;

  assign pc_en       = !reset & !in_wait & !run_stall;
  assign ifid_en     = !reset & !in_wait & !run_stall;
  assign idex_en     = !reset & !in_wait;
  assign ifid_flush  = reset | run_br;
  assign idex_flush  = reset | run_br | run_stall;
  assign exmem_flush = reset | in_wait;
  assign stall_count = stall_count_q;
  assign mul_timeout = mul_timeout_q;

  assign mul_last = mul_cnt_q == MC_LAST;
  assign mul_end  = in_wait & (mul_done | mul_last);

  always_comb begin
    state_d       = in_wait ? (mul_end ? RUN : MUL_WAIT) : (mul_start ? MUL_WAIT : RUN);
    mul_cnt_d     = (in_wait & !mul_end) ? mul_cnt_q + 1'b1 : '0;
    mul_timeout_d = mul_timeout_q | (in_wait & !mul_done & mul_last);
    stall_count_d = (!pc_en && stall_count_q != '1) ? stall_count_q + 1'b1 : stall_count_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      mul_cnt_q     <= '0;
      stall_count_q <= '0;
      mul_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      mul_cnt_q     <= mul_cnt_d;
      stall_count_q <= stall_count_d;
      mul_timeout_q <= mul_timeout_d;
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed and random stimulus scored against a behavioural hazard model.
module tb_pipeline_hazard_ctrl;
  localparam int CW  = 4;
  localparam int MAX = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1, id_valid = 1'b0, id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0, mem_rd = '0;
  logic ex_regwrite = 1'b0, ex_memread = 1'b0, mem_regwrite = 1'b0;
  logic br_taken = 1'b0, mul_start = 1'b0, mul_done = 1'b0;
  logic pc_en, ifid_en, idex_en, ifid_flush, idex_flush, exmem_flush, mul_timeout;
  logic [CW-1:0] stall_count;

  pipeline_hazard_ctrl #(.REG_W(5), .ZERO_REG(31), .MUL_MAX_CYC(MAX), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .br_taken(br_taken),
    .mul_start(mul_start), .mul_done(mul_done), .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .stall_count(stall_count), .mul_timeout(mul_timeout)
  );

  typedef struct packed {
    logic rst, idv;
    logic [4:0] rs1, rs2;
    logic u1, u2;
    logic [4:0] exrd;
    logic exrw, exmr;
    logic [4:0] memrd;
    logic memrw, br, ms, md;
  } stim_t;

  typedef struct packed {
    logic pc, ifid, idex, fif, fidex, fexm;
    logic [CW-1:0] sc;
    logic tmo;
  } resp_t;

  resp_t q[$];
  int checks = 0, errors = 0;
  bit m_mul = 0, m_tmo = 0;
  int m_wait = 0, m_sc = 0;

  function automatic bit dep(logic v, logic u, logic [4:0] s, logic w, logic [4:0] rd);
    return v & u & w & (rd == s) & (s != 5'd31);
  endfunction

  function automatic stim_t idle();
    stim_t s = '0;
    s.idv = 1'b1;
    return s;
  endfunction

  function automatic logic [4:0] rr();
    int k = $urandom_range(0, 4);
    return k == 4 ? 5'd31 : 5'(k);
  endfunction

  task automatic step(input stim_t s);
    resp_t e;
    bit stall, any_dep, lu;
    @(negedge clk);
    reset = s.rst; id_valid = s.idv; id_rs1 = s.rs1; id_rs2 = s.rs2;
    id_use_rs1 = s.u1; id_use_rs2 = s.u2; ex_rd = s.exrd; ex_regwrite = s.exrw;
    ex_memread = s.exmr; mem_rd = s.memrd; mem_regwrite = s.memrw;
    br_taken = s.br; mul_start = s.ms; mul_done = s.md;
    e.sc = CW'(m_sc);
    e.tmo = m_tmo;
    if (s.rst) begin
      {e.pc, e.ifid, e.idex, e.fif, e.fidex, e.fexm} = 6'b000111;
      m_mul = 0; m_wait = 0; m_sc = 0; m_tmo = 0;
    end else if (m_mul) begin
      {e.pc, e.ifid, e.idex, e.fif, e.fidex, e.fexm} = 6'b000001;
      m_wait++;
      if (s.md || m_wait == MAX) begin
        if (!s.md) m_tmo = 1;
        m_mul = 0;
        m_wait = 0;
      end
    end else begin
      {e.pc, e.ifid, e.idex, e.fif, e.fidex, e.fexm} = 6'b111000;
      lu = s.exmr & (dep(s.idv, s.u1, s.rs1, s.exrw, s.exrd) | dep(s.idv, s.u2, s.rs2, s.exrw, s.exrd));
      any_dep = dep(s.idv, s.u1, s.rs1, s.exrw, s.exrd) | dep(s.idv, s.u2, s.rs2, s.exrw, s.exrd) |
                dep(s.idv, s.u1, s.rs1, s.memrw, s.memrd) | dep(s.idv, s.u2, s.rs2, s.memrw, s.memrd);
`ifdef PIPE_FWD_EN
      stall = lu;
`else
      stall = any_dep;
`endif
      if (s.ms) m_mul = 1;
      else if (s.br) begin e.fif = 1; e.fidex = 1; end
      else if (stall) begin e.pc = 0; e.ifid = 0; e.fidex = 1; end
    end
    if (!s.rst && !e.pc) m_sc = (m_sc < 2**CW - 1) ? m_sc + 1 : 2**CW - 1;
    q.push_back(e);
  endtask

  initial begin
    resp_t e, a;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        a = {pc_en, ifid_en, idex_en, ifid_flush, idex_flush, exmem_flush, stall_count, mul_timeout};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL cyc%0d {pc,ifid,idex,fif,fidex,fexm,sc,tmo} got %b want %b", checks, a, e);
        end
      end
    end
  end

  initial begin
    stim_t s, lu;
    s = idle(); s.rst = 1;
    repeat (2) step(s);
    repeat (2) step(idle());
    lu = idle(); lu.exmr = 1; lu.exrw = 1; lu.exrd = 3; lu.rs1 = 3; lu.u1 = 1;
    step(lu);
    s = idle(); s.rs1 = 3; s.u1 = 1; s.memrd = 3; s.memrw = 1;
    step(s);
    step(idle());
    s = idle(); s.exrw = 1; s.exrd = 31; s.rs2 = 31; s.u2 = 1; s.memrw = 1; s.memrd = 31;
    step(s);
    s = lu; s.br = 1;
    step(s);
    s = idle(); s.ms = 1;
    step(s);
    repeat (4) step(idle());
    s = idle(); s.md = 1;
    step(s);
    step(idle());
    s = idle(); s.ms = 1;
    step(s);
    s = idle(); s.md = 1;
    step(s);
    step(idle());
    s = idle(); s.ms = 1;
    step(s);
    repeat (MAX) step(idle());
    step(idle());
    s = idle(); s.ms = 1;
    step(s);
    repeat (9) step(idle());
    s = idle(); s.rst = 1;
    step(s);
    step(idle());
    repeat (3000) begin
      s.rst = ($urandom_range(0, 199) == 0);
      s.idv = ($urandom_range(0, 7) != 0);
      s.rs1 = rr(); s.rs2 = rr(); s.exrd = rr(); s.memrd = rr();
      s.u1 = 1'($urandom); s.u2 = 1'($urandom);
      s.exrw = 1'($urandom); s.exmr = 1'($urandom); s.memrw = 1'($urandom);
      s.br = ($urandom_range(0, 5) == 0);
      s.ms = ($urandom_range(0, 15) == 0);
      s.md = ($urandom_range(0, 29) == 0);
      step(s);
    end
    @(negedge clk);
    #5;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
